// File: rtl/quartz_countdown.sv
// Purpose : two-digit BCD countdown started by the latched quarantine flag
//           QUARTZ. At zero it raises resetQUAR and holds it until the flag
//           owner acknowledges with resetFLAG, then re-arms.
// Latency : the load happens on the edge that samples QUARTZ=1. resetQUAR
//           rises N*TICKS_PER_STEP non-held edges later (N = start value).
// Backpressure: HOLD freezes the prescaler and the digits while counting.
//           EXPIRE waits indefinitely for resetFLAG. No other flow control.
//
// Ports:
//   SLOWCLOCK  in   clock, every flop updates on the rising edge
//   RESET      in   synchronous active-high reset, overrides all inputs
//   QUARTZ     in   quarantine flag level from the flag owner
//   resetFLAG  in   acknowledge from the flag owner, used only in EXPIRE
//   HOLD       in   freezes the countdown while high (ignored in EXPIRE)
//   resetQUAR  out  request to clear QUARTZ (registered)
//   TENS       out  BCD tens digit (registered)
//   UNITS      out  BCD units digit (registered)
//   ACTIVE     out  high in COUNT and EXPIRE (registered)
module quartz_countdown #(
  parameter int unsigned START_TENS     = 1,
  parameter int unsigned START_UNITS    = 4,
  parameter int unsigned TICKS_PER_STEP = 1,
  parameter int unsigned TICK_W         = 8
) (
  input  logic       SLOWCLOCK,
  input  logic       RESET,
  input  logic       QUARTZ,
  input  logic       resetFLAG,
  input  logic       HOLD,
  output logic       resetQUAR,
  output logic [3:0] TENS,
  output logic [3:0] UNITS,
  output logic       ACTIVE
);

  localparam logic [3:0]        LOAD_TENS  = 4'(START_TENS);
  localparam logic [3:0]        LOAD_UNITS = 4'(START_UNITS);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_STEP - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          tens_q, tens_d;
  logic [3:0]          units_q, units_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                rq_q, rq_d;
  logic                active_q, active_d;

  // One-count decrement of the current BCD value, saturating at 00.
  logic [3:0]          tens_dec, units_dec;
  logic                dec_is_zero;

  always_comb begin
    tens_dec  = tens_q;
    units_dec = units_q;
    if (units_q != 4'd0) begin
      units_dec = units_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      units_dec = 4'd9;
      tens_dec  = tens_q - 4'd1;
    end
    dec_is_zero = (tens_dec == 4'd0) && (units_dec == 4'd0);
  end

  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    units_d  = units_q;
    tick_d   = tick_q;
    rq_d     = rq_q;
    active_d = active_q;

    case (state_q)
      IDLE: begin
        tens_d   = LOAD_TENS;
        units_d  = LOAD_UNITS;
        tick_d   = '0;
        rq_d     = 1'b0;
        active_d = 1'b0;
        if (QUARTZ) begin
          state_d  = COUNT;
          active_d = 1'b1;
        end
      end

      COUNT: begin
        // Losing the flag mid-count abandons the run; it wins over a step.
        if (!QUARTZ) begin
          state_d  = IDLE;
          tens_d   = LOAD_TENS;
          units_d  = LOAD_UNITS;
          tick_d   = '0;
          rq_d     = 1'b0;
          active_d = 1'b0;
        end else if (!HOLD) begin
          if (tick_q < TICK_LAST) begin
            tick_d = tick_q + TICK_W'(1);
          end else begin
            tick_d  = '0;
            tens_d  = tens_dec;
            units_d = units_dec;
            // The edge that writes 00 also raises the clear request.
            if (dec_is_zero) begin
              state_d = EXPIRE;
              rq_d    = 1'b1;
            end
          end
        end
      end

      EXPIRE: begin
        rq_d    = 1'b1;
        tens_d  = 4'd0;
        units_d = 4'd0;
        if (resetFLAG) begin
          state_d  = IDLE;
          tens_d   = LOAD_TENS;
          units_d  = LOAD_UNITS;
          tick_d   = '0;
          rq_d     = 1'b0;
          active_d = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        tens_d   = LOAD_TENS;
        units_d  = LOAD_UNITS;
        tick_d   = '0;
        rq_d     = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SLOWCLOCK) begin
    if (RESET) begin
      state_q  <= IDLE;
      tens_q   <= LOAD_TENS;
      units_q  <= LOAD_UNITS;
      tick_q   <= '0;
      rq_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
      tick_q   <= tick_d;
      rq_q     <= rq_d;
      active_q <= active_d;
    end
  end

  assign resetQUAR = rq_q;
  assign TENS      = tens_q;
  assign UNITS     = units_q;
  assign ACTIVE    = active_q;

endmodule

// File: tb/tb_quartz_countdown.sv
// Purpose : scoreboard bench for quartz_countdown; instance A uses defaults
//           (start 14, one tick per step), instance B uses start 02 with a
//           prescale of three ticks per step.
// Latency : expectations are queued when inputs are driven and compared
//           1 time unit after the next rising edge.
// Backpressure: none; every scenario is a fixed-length stimulus table.
module tb_quartz_countdown;

  logic clk;
  logic rst_a, q_a, flag_a, hold_a;
  logic rst_b, q_b, flag_b, hold_b;
  logic       rq_a_o, act_a_o, rq_b_o, act_b_o;
  logic [3:0] tens_a_o, units_a_o, tens_b_o, units_b_o;

  int checks = 0;
  int errors = 0;

  // Expected {resetQUAR, ACTIVE, TENS, UNITS}, one entry per driven edge.
  logic [9:0] sb_a[$];
  logic [9:0] sb_b[$];

  // Stimulus table under construction: {RESET, QUARTZ, resetFLAG, HOLD}.
  logic [3:0] st_q[$];
  logic [9:0] ev_q[$];

  quartz_countdown dut_a (
    .SLOWCLOCK(clk), .RESET(rst_a), .QUARTZ(q_a), .resetFLAG(flag_a),
    .HOLD(hold_a), .resetQUAR(rq_a_o), .TENS(tens_a_o), .UNITS(units_a_o),
    .ACTIVE(act_a_o)
  );

  quartz_countdown #(
    .START_TENS(0), .START_UNITS(2), .TICKS_PER_STEP(3), .TICK_W(8)
  ) dut_b (
    .SLOWCLOCK(clk), .RESET(rst_b), .QUARTZ(q_b), .resetFLAG(flag_b),
    .HOLD(hold_b), .resetQUAR(rq_b_o), .TENS(tens_b_o), .UNITS(units_b_o),
    .ACTIVE(act_b_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output word for a plain decimal count value.
  function automatic logic [9:0] ex(input bit rq, input bit act, input int v);
    ex = {rq, act, 4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic add(input bit rst, input bit q, input bit flag, input bit hold,
                     input bit rq, input bit act, input int v);
    st_q.push_back({rst, q, flag, hold});
    ev_q.push_back(ex(rq, act, v));
  endtask

  // Load edge plus 14 count edges ending in 00 with resetQUAR raised.
  task automatic add_count_a();
    add(0, 1, 0, 0, 0, 1, 14);
    for (int k = 1; k <= 14; k++) add(0, 1, 0, 0, k == 14, 1, 14 - k);
  endtask

  task automatic test_reset();
    logic [9:0] e;
    st_q.delete(); ev_q.delete();
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 0, 0, 14);
    // Stray resetFLAG and HOLD in IDLE must have no effect.
    for (int i = 0; i < 20; i++) add(0, 0, i % 5 == 0, i % 3 == 0, 0, 0, 14);
    for (int i = 0; i < st_q.size(); i++) begin
      {rst_a, q_a, flag_a, hold_a} = st_q[i];
      {rst_b, q_b, flag_b, hold_b} = st_q[i];
      sb_a.push_back(ev_q[i]);
      sb_b.push_back(ex(0, 0, 2));
      @(posedge clk); #1;
      e = sb_a.pop_front(); checks++;
      if ({rq_a_o, act_a_o, tens_a_o, units_a_o} !== e) begin
        errors++;
        $display("FAIL reset_a[%0d]: got %03h want %03h", i, {rq_a_o, act_a_o, tens_a_o, units_a_o}, e);
      end
      e = sb_b.pop_front(); checks++;
      if ({rq_b_o, act_b_o, tens_b_o, units_b_o} !== e) begin
        errors++;
        $display("FAIL reset_b[%0d]: got %03h want %03h", i, {rq_b_o, act_b_o, tens_b_o, units_b_o}, e);
      end
    end
  endtask

  // Count 14..00 with the flag owner answering one edge after each change.
  task automatic test_full_count(input string name);
    logic [9:0] e;
    st_q.delete(); ev_q.delete();
    add_count_a();
    add(0, 1, 0, 1, 1, 1, 0);   // owner not yet reacted; HOLD ignored
    add(0, 0, 1, 0, 0, 0, 14);  // acknowledge sampled: back to IDLE
    add(0, 0, 1, 0, 0, 0, 14);  // ack still high in IDLE: ignored
    add(0, 0, 0, 0, 0, 0, 14);
    for (int i = 0; i < st_q.size(); i++) begin
      {rst_a, q_a, flag_a, hold_a} = st_q[i];
      sb_a.push_back(ev_q[i]);
      @(posedge clk); #1;
      e = sb_a.pop_front(); checks++;
      if ({rq_a_o, act_a_o, tens_a_o, units_a_o} !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %03h want %03h", name, i, {rq_a_o, act_a_o, tens_a_o, units_a_o}, e);
      end
    end
  endtask

  task automatic test_prescale_hold();
    logic [9:0] e;
    st_q.delete(); ev_q.delete();
    add(0, 1, 0, 0, 0, 1, 2);                          // load
    add(0, 1, 0, 0, 0, 1, 2);                          // tick 1
    for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 0, 1, 2); // frozen
    add(0, 1, 0, 0, 0, 1, 2);                          // tick 2
    add(0, 1, 0, 0, 0, 1, 1);                          // 3+4 edges: 01
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 1, 1, 0);                          // 3 more: 00
    for (int i = 0; i < st_q.size(); i++) begin
      {rst_b, q_b, flag_b, hold_b} = st_q[i];
      sb_b.push_back(ev_q[i]);
      @(posedge clk); #1;
      e = sb_b.pop_front(); checks++;
      if ({rq_b_o, act_b_o, tens_b_o, units_b_o} !== e) begin
        errors++;
        $display("FAIL prescale[%0d]: got %03h want %03h", i, {rq_b_o, act_b_o, tens_b_o, units_b_o}, e);
      end
    end
  endtask

  // Continues from EXPIRE on instance B.
  task automatic test_late_ack();
    logic [9:0] e;
    st_q.delete(); ev_q.delete();
    for (int i = 0; i < 50; i++) add(0, i < 3, 0, i % 2 == 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < st_q.size(); i++) begin
      {rst_b, q_b, flag_b, hold_b} = st_q[i];
      sb_b.push_back(ev_q[i]);
      @(posedge clk); #1;
      e = sb_b.pop_front(); checks++;
      if ({rq_b_o, act_b_o, tens_b_o, units_b_o} !== e) begin
        errors++;
        $display("FAIL late_ack[%0d]: got %03h want %03h", i, {rq_b_o, act_b_o, tens_b_o, units_b_o}, e);
      end
    end
  endtask

  task automatic test_abnormal();
    logic [9:0] e;
    st_q.delete(); ev_q.delete();
    add(0, 1, 0, 0, 0, 1, 14);
    for (int k = 1; k <= 7; k++) add(0, 1, 0, 0, 0, 1, 14 - k);  // reaches 07
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0, 14);      // flag lost
    for (int i = 0; i < st_q.size(); i++) begin
      {rst_a, q_a, flag_a, hold_a} = st_q[i];
      sb_a.push_back(ev_q[i]);
      @(posedge clk); #1;
      e = sb_a.pop_front(); checks++;
      if ({rq_a_o, act_a_o, tens_a_o, units_a_o} !== e) begin
        errors++;
        $display("FAIL abnormal[%0d]: got %03h want %03h", i, {rq_a_o, act_a_o, tens_a_o, units_a_o}, e);
      end
    end
  endtask

  task automatic test_reset_expire();
    logic [9:0] e;
    st_q.delete(); ev_q.delete();
    add_count_a();
    add(0, 1, 0, 0, 1, 1, 0);   // QUARTZ still high in EXPIRE: no restart
    add(1, 1, 0, 0, 0, 0, 14);  // RESET wins over EXPIRE
    add(0, 0, 0, 0, 0, 0, 14);
    add(0, 1, 0, 0, 0, 1, 14);  // short run, then RESET mid-count
    add(0, 1, 0, 0, 0, 1, 13);
    add(1, 1, 0, 0, 0, 0, 14);
    add(0, 0, 0, 0, 0, 0, 14);
    for (int i = 0; i < st_q.size(); i++) begin
      {rst_a, q_a, flag_a, hold_a} = st_q[i];
      sb_a.push_back(ev_q[i]);
      @(posedge clk); #1;
      e = sb_a.pop_front(); checks++;
      if ({rq_a_o, act_a_o, tens_a_o, units_a_o} !== e) begin
        errors++;
        $display("FAIL reset_expire[%0d]: got %03h want %03h", i, {rq_a_o, act_a_o, tens_a_o, units_a_o}, e);
      end
    end
  endtask

  task automatic test_rearm();
    test_full_count("rearm_first");
    test_full_count("rearm_second");
  endtask

  initial begin
    rst_a = 1'b1; q_a = 1'b0; flag_a = 1'b0; hold_a = 1'b0;
    rst_b = 1'b1; q_b = 1'b0; flag_b = 1'b0; hold_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_count("full");
    test_prescale_hold();
    test_late_ack();
    test_abnormal();
    test_reset_expire();
    test_rearm();
    checks++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", sb_a.size(), sb_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
